// File: rtl/asrv32_memoryaccess.sv
// asrv32_memoryaccess: RV32 load/store stage driving a Wishbone data bus.
// Ports:
//   i_clk, i_rst_n           clock, synchronous active-low reset
//   i_ce                     stage enable (core in MEMORYACCESS)
//   i_opcode_load/_store     decoded opcode, one-hot
//   i_funct3, i_y            access size/sign, effective byte address
//   i_rs2_data               store data
//   o_wb_cyc/stb/we/addr/data/sel, i_wb_ack, i_wb_data   Wishbone master
//   o_load_data              extended load result
//   o_done, o_stall          completion pulse, access outstanding
//   o_misaligned, o_bus_err  fault pulses (alignment, ack timeout)
module asrv32_memoryaccess #(
  parameter int ACK_TIMEOUT = 255
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_ce,
  input  logic        i_opcode_load,
  input  logic        i_opcode_store,
  input  logic [2:0]  i_funct3,
  input  logic [31:0] i_y,
  input  logic [31:0] i_rs2_data,
  output logic        o_wb_cyc,
  output logic        o_wb_stb,
  output logic        o_wb_we,
  output logic [31:0] o_wb_addr,
  output logic [31:0] o_wb_data,
  output logic [3:0]  o_wb_sel,
  input  logic        i_wb_ack,
  input  logic [31:0] i_wb_data,
  output logic [31:0] o_load_data,
  output logic        o_done,
  output logic        o_stall,
  output logic        o_misaligned,
  output logic        o_bus_err
);
  typedef enum logic {IDLE, WAIT} state_t;
  state_t      state;
  logic [15:0] cnt;
  logic [2:0]  f3_q;
  logic [1:0]  off_q;
  logic        load_ok, store_ok, mis;
  logic [3:0]  sel_n;
  logic [31:0] data_n, ld_n;
  logic [7:0]  b;
  logic [15:0] h;
  assign o_stall = (state == WAIT);
  always_comb begin
    load_ok  = i_opcode_load && (i_funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
    store_ok = i_opcode_store && !i_funct3[2] && (i_funct3[1:0] != 2'b11);
    mis      = (i_funct3[1:0] == 2'b01 && i_y[0]) || (i_funct3[1:0] == 2'b10 && i_y[1:0] != 2'b00);
    sel_n    = i_funct3[1:0] == 2'b00 ? 4'b0001 << i_y[1:0] :
               i_funct3[1:0] == 2'b01 ? 4'b0011 << {i_y[1], 1'b0} : 4'b1111;
    data_n   = !i_opcode_store ? 32'h0 :
               i_funct3[1:0] == 2'b00 ? {4{i_rs2_data[7:0]}} :
               i_funct3[1:0] == 2'b01 ? {2{i_rs2_data[15:0]}} : i_rs2_data;
    // Read-lane extraction uses the funct3/offset latched at request time.
    b        = i_wb_data[{off_q, 3'b000} +: 8];
    h        = off_q[1] ? i_wb_data[31:16] : i_wb_data[15:0];
    ld_n     = f3_q[1:0] == 2'b00 ? {{24{b[7] & ~f3_q[2]}}, b} :
               f3_q[1:0] == 2'b01 ? {{16{h[15] & ~f3_q[2]}}, h} : i_wb_data;
  end
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state        <= IDLE;
      cnt          <= '0;
      f3_q         <= '0;
      off_q        <= '0;
      o_wb_cyc     <= 1'b0;
      o_wb_stb     <= 1'b0;
      o_wb_we      <= 1'b0;
      o_wb_addr    <= '0;
      o_wb_data    <= '0;
      o_wb_sel     <= '0;
      o_load_data  <= '0;
      o_done       <= 1'b0;
      o_misaligned <= 1'b0;
      o_bus_err    <= 1'b0;
    end else begin
      o_done       <= 1'b0;
      o_misaligned <= 1'b0;
      o_bus_err    <= 1'b0;
      if (state == IDLE) begin
        // A held i_ce is not re-accepted in the cycle o_done is presented.
        if (i_ce && !o_done) begin
          if ((load_ok || store_ok) && !mis) begin
            state     <= WAIT;
            cnt       <= '0;
            f3_q      <= i_funct3;
            off_q     <= i_y[1:0];
            o_wb_cyc  <= 1'b1;
            o_wb_stb  <= 1'b1;
            o_wb_we   <= i_opcode_store;
            o_wb_addr <= {i_y[31:2], 2'b00};
            o_wb_sel  <= sel_n;
            o_wb_data <= data_n;
          end else begin
            o_done       <= 1'b1;
            o_misaligned <= (load_ok || store_ok) && mis;
          end
        end
      end else if (i_wb_ack) begin
        state    <= IDLE;
        o_wb_cyc <= 1'b0;
        o_wb_stb <= 1'b0;
        o_wb_we  <= 1'b0;
        o_done   <= 1'b1;
        if (!o_wb_we) o_load_data <= ld_n;
      end else if (cnt == 16'(ACK_TIMEOUT - 1)) begin
        state     <= IDLE;
        o_wb_cyc  <= 1'b0;
        o_wb_stb  <= 1'b0;
        o_wb_we   <= 1'b0;
        o_done    <= 1'b1;
        o_bus_err <= 1'b1;
      end else begin
        cnt <= cnt + 16'd1;
      end
    end
  end
endmodule

// File: tb/tb_asrv32_memoryaccess.sv
// tb_asrv32_memoryaccess: directed plus random transactions against an arithmetic reference model.
module tb_asrv32_memoryaccess;
  localparam int TO = 4;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ce = 1'b0, op_load = 1'b0, op_store = 1'b0;
  logic [2:0]  funct3 = '0;
  logic [31:0] y = '0, rs2 = '0;
  logic        wb_cyc, wb_stb, wb_we, wb_ack = 1'b0;
  logic [31:0] wb_addr, wb_wdata, wb_rdata = '0, load_data;
  logic [3:0]  wb_sel;
  logic        done, stall, misaligned, bus_err;
  int          checks = 0, errors = 0;
  logic [31:0] exp_ld = '0;

  asrv32_memoryaccess #(.ACK_TIMEOUT(TO)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_ce(ce),
    .i_opcode_load(op_load), .i_opcode_store(op_store),
    .i_funct3(funct3), .i_y(y), .i_rs2_data(rs2),
    .o_wb_cyc(wb_cyc), .o_wb_stb(wb_stb), .o_wb_we(wb_we),
    .o_wb_addr(wb_addr), .o_wb_data(wb_wdata), .o_wb_sel(wb_sel),
    .i_wb_ack(wb_ack), .i_wb_data(wb_rdata),
    .o_load_data(load_data), .o_done(done), .o_stall(stall),
    .o_misaligned(misaligned), .o_bus_err(bus_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] ld_model(input logic [2:0] f3, input logic [1:0] off, input logic [31:0] d);
    int bits = 8 << f3[1:0];
    longint v = longint'(d >> (8 * off));
    if (bits < 32) begin
      v = v % (longint'(1) << bits);
      if (!f3[2] && v >= (longint'(1) << (bits - 1))) v = v - (longint'(1) << bits);
    end
    return 32'(v);
  endfunction

  // op: 0 none, 1 load, 2 store; waits: WAIT cycles before ack, -1 never acks
  task automatic txn(input int op, input logic [2:0] f3, input logic [31:0] ya, input logic [31:0] sd,
                     input int waits, input logic [31:0] rd);
    int size = 1 << f3[1:0];
    bit valid = (op == 1) ? (f3 != 3 && f3 < 6) : (op == 2) ? (f3 < 3) : 1'b0;
    bit mis = (ya % size) != 0;
    logic [3:0] sel = 4'(((1 << size) - 1) << (ya % 4));
    logic [31:0] wd = (op != 2) ? 32'h0 : size == 1 ? sd[7:0] * 32'h01010101 :
                      size == 2 ? sd[15:0] * 32'h00010001 : sd;
    bit acked = 0;
    chk("pre_done", {31'b0, done}, 0);
    ce = 1; op_load = (op == 1); op_store = (op == 2); funct3 = f3; y = ya; rs2 = sd;
    step();
    ce = 0; op_load = 0; op_store = 0; funct3 = 3'($urandom); y = $urandom; rs2 = $urandom;
    if (!valid || mis) begin
      chk("fast_cyc", {31'b0, wb_cyc}, 0);
      chk("fast_done", {31'b0, done}, 1);
      chk("fast_mis", {31'b0, misaligned}, {31'b0, valid && mis});
      chk("fast_berr", {31'b0, bus_err}, 0);
      chk("fast_ld", load_data, exp_ld);
      step();
      chk("fast_pulse", {31'b0, done}, 0);
      return;
    end
    chk("req_cyc", {31'b0, wb_cyc}, 1);
    chk("req_stb", {31'b0, wb_stb}, 1);
    chk("req_we", {31'b0, wb_we}, {31'b0, op == 2});
    chk("req_addr", wb_addr, {ya[31:2], 2'b00});
    chk("req_sel", {28'b0, wb_sel}, {28'b0, sel});
    chk("req_data", wb_wdata, wd);
    chk("req_stall", {31'b0, stall}, 1);
    chk("req_done", {31'b0, done}, 0);
    for (int k = 0; k < TO; k++) begin
      wb_ack = (k == waits);
      wb_rdata = wb_ack ? rd : $urandom;
      ce = 1'($urandom);
      acked = wb_ack;
      step();
      wb_ack = 0; ce = 0;
      if (acked || k == TO - 1) break;
      chk("hold_cyc", {31'b0, wb_cyc}, 1);
      chk("hold_addr", wb_addr, {ya[31:2], 2'b00});
      chk("hold_sel", {28'b0, wb_sel}, {28'b0, sel});
      chk("hold_data", wb_wdata, wd);
      chk("hold_done", {31'b0, done}, 0);
    end
    if (acked && op == 1) exp_ld = ld_model(f3, ya[1:0], rd);
    chk("end_cyc", {31'b0, wb_cyc}, 0);
    chk("end_stb", {31'b0, wb_stb}, 0);
    chk("end_done", {31'b0, done}, 1);
    chk("end_berr", {31'b0, bus_err}, {31'b0, !acked});
    chk("end_mis", {31'b0, misaligned}, 0);
    chk("end_stall", {31'b0, stall}, 0);
    chk("end_ld", load_data, exp_ld);
    step();
    chk("end_pulse", {31'b0, done}, 0);
    chk("end_berr_pulse", {31'b0, bus_err}, 0);
  endtask

  initial begin
    step();
    step();
    chk("rst_cyc", {31'b0, wb_cyc}, 0);
    chk("rst_addr", wb_addr, 0);
    chk("rst_sel", {28'b0, wb_sel}, 0);
    chk("rst_ld", load_data, 0);
    chk("rst_done", {31'b0, done | stall | misaligned | bus_err}, 0);
    rst_n = 1;
    step();
    // LW, zero wait states
    txn(1, 3'b010, 32'h100, 32'h0, 0, 32'hDEADBEEF);
    chk("lw_result", load_data, 32'hDEADBEEF);
    // LB / LBU with 3 wait states (ack coincides with timeout edge: ack wins)
    txn(1, 3'b000, 32'h103, 32'h0, 3, 32'h80112233);
    chk("lb_result", load_data, 32'hFFFFFF80);
    txn(1, 3'b100, 32'h103, 32'h0, 3, 32'h80112233);
    chk("lbu_result", load_data, 32'h00000080);
    // SH upper half
    txn(2, 3'b001, 32'h202, 32'h0000ABCD, 1, 32'h0);
    chk("sh_keeps_ld", load_data, 32'h00000080);
    // Misaligned LW
    txn(1, 3'b010, 32'h101, 32'h0, 0, 32'h0);
    // Timeout
    txn(1, 3'b010, 32'h300, 32'h0, -1, 32'h0);
    // Invalid funct3 and no opcode
    txn(1, 3'b011, 32'h0, 32'h0, 0, 32'h0);
    txn(2, 3'b100, 32'h0, 32'h0, 0, 32'h0);
    txn(0, 3'b010, 32'h0, 32'h0, 0, 32'h0);
    // Ack while idle is ignored
    wb_ack = 1; wb_rdata = 32'h12345678;
    step();
    chk("idle_ack_cyc", {31'b0, wb_cyc}, 0);
    chk("idle_ack_done", {31'b0, done}, 0);
    chk("idle_ack_ld", load_data, exp_ld);
    wb_ack = 0;
    // Reset during WAIT aborts; late ack ignored
    ce = 1; op_load = 1; funct3 = 3'b010; y = 32'h400;
    step();
    ce = 0; op_load = 0;
    chk("rw_cyc", {31'b0, wb_cyc}, 1);
    rst_n = 0;
    step();
    rst_n = 1; wb_ack = 1; wb_rdata = 32'hCAFEF00D;
    exp_ld = 0;
    chk("rw_cyc_low", {31'b0, wb_cyc}, 0);
    chk("rw_done", {31'b0, done}, 0);
    chk("rw_ld", load_data, 0);
    step();
    wb_ack = 0;
    chk("rw_late_done", {31'b0, done}, 0);
    chk("rw_late_cyc", {31'b0, wb_cyc}, 0);
    step();
    // Random transactions
    for (int n = 0; n < 200; n++) begin
      int w = $urandom_range(0, 4);
      int op = $urandom_range(0, 2);
      logic [31:0] ya = $urandom;
      if ($urandom_range(0, 1) == 1) ya[1:0] = 2'b00;
      txn(op, 3'($urandom), ya, $urandom, (w == 4) ? -1 : w, $urandom);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
